instr_sequencer: RTL
====================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter PC_WIDTH, default 8, giving the program counter width in bits (minimum 4).
REQ-002 The block SHALL have parameter RESET_PC, default 0, giving the PC value loaded on reset.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port run, input, 1, a level enable that permits instruction issue.
REQ-006 The block SHALL have port instr_req, output, 1, an instruction-memory read request.
REQ-007 The block SHALL have port pc, output, PC_WIDTH, the fetch address.
REQ-008 The block SHALL have port instr_data, input, 8, the fetched instruction; [7:4] is the ALU code and [3:0] is the operand.
REQ-009 The block SHALL have port instr_valid, input, 1, which marks instr_data valid for the current request.
REQ-010 The block SHALL have port alu_code, output, 4, the registered ALU code fed to the ALU op decoder.
REQ-011 The block SHALL have port operand, output, 4, the registered immediate operand.
REQ-012 The block SHALL have port alu_en, output, 1, a one-cycle execute strobe.
REQ-013 The block SHALL have port wb_en, output, 1, a one-cycle writeback strobe.
REQ-014 The block SHALL have port halted, output, 1, which is high while in HALT.
REQ-015 The block SHALL have port illegal, output, 1, a sticky flag for an undefined ALU code.

Function
REQ-016 The block SHALL implement the FSM states IDLE, FETCH, DECODE, EXEC, WB and HALT.
REQ-017 The block SHALL decode instr_req, alu_en, wb_en and halted from the current state only: instr_req=FETCH, alu_en=EXEC, wb_en=WB, halted=HALT.
REQ-018 IDLE: the block SHALL go to FETCH if run=1, else stay in IDLE.
REQ-019 FETCH: the block SHALL hold instr_req=1 until instr_valid=1, and on that edge capture instr_data into the instruction register, set pc to pc+1 modulo 2^PC_WIDTH, and go to DECODE.
REQ-020 The block SHALL ignore instr_valid in every state other than FETCH.
REQ-021 DECODE: the block SHALL load alu_code with IR[7:4] and operand with IR[3:0] on the exit edge.
REQ-022 DECODE with codes 0000-1010: the block SHALL go to EXEC.
REQ-023 DECODE with code 1011 (JUMP): the block SHALL load pc with the zero-extended operand, skip EXEC and WB, and go to FETCH if run=1, else IDLE.
REQ-024 DECODE with code 1100 (HALT): the block SHALL go to HALT.
REQ-025 DECODE with codes 1101-1111: the block SHALL set illegal=1, treat the instruction as a NOP with no alu_en and no wb_en, and go to FETCH if run=1, else IDLE.
REQ-026 EXEC: the block SHALL assert alu_en for exactly one cycle and then go to WB.
REQ-027 WB: the block SHALL assert wb_en for exactly one cycle and then go to FETCH if run=1, else IDLE.
REQ-028 The block SHALL sample run only in IDLE, WB and the DECODE-exit cases above; deasserting run mid-instruction SHALL let the current instruction complete.
REQ-029 HALT: the block SHALL remain in HALT, ignoring run and instr_valid, until rst.
REQ-030 The block SHALL hold alu_code and operand stable from the DECODE exit edge until the next DECODE exit edge.
REQ-031 When instr_valid is high in the first FETCH cycle, an ALU instruction SHALL take exactly 4 cycles (FETCH, DECODE, EXEC, WB) and back-to-back issue SHALL give one alu_en every 4 cycles.
REQ-032 On PC wrap, pc SHALL go from 2^PC_WIDTH-1 to 0 with no flag.

Reset
REQ-033 When rst=1 at a clock edge, the block SHALL set state to IDLE, pc to RESET_PC, the instruction register, alu_code and operand to 0, and illegal to 0, taking priority over all other inputs.
REQ-034 After reset, instr_req, alu_en, wb_en and halted SHALL be 0 until the state changes.
REQ-035 A reset asserted in any state, including HALT and mid-FETCH, SHALL abort the instruction with no alu_en or wb_en on the reset edge.

Verification
REQ-036 Bench: rst, then run=1 and memory returning 0x35 with instr_valid in the same cycle as the request -> instr_req at cycle 1, alu_code=3 and operand=5 from cycle 3, alu_en at cycle 3, wb_en at cycle 4, pc=1.
REQ-037 Bench: instr_valid delayed 3 cycles in FETCH -> instr_req stays high for 4 cycles, pc unchanged until capture, and no alu_en during the wait.
REQ-038 Bench: instruction 0xB7 at pc=4 -> pc=7 after DECODE, no alu_en or wb_en, next fetch at address 7.
REQ-039 Bench: instruction 0xE0 -> illegal=1 and remains 1 across later legal instructions; instruction 0xC0 -> halted=1 held for 20 cycles with run=1.
REQ-040 Bench: PC_WIDTH=4 with pc=15 fetching -> pc wraps to 0; rst asserted during EXEC -> next cycle shows IDLE with pc=RESET_PC and alu_en=0.

Source files
------------

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle instruction sequencer. It fetches one 8-bit instruction at a
// time from an external instruction memory, decodes it, and strobes the ALU
// and the register-file writeback.
//
// Instruction format: [7:4] ALU code, [3:0] immediate operand.
//   0000-1010 : ALU op       FETCH -> DECODE -> EXEC -> WB
//   1011      : JUMP         pc <= zero-extended operand, no EXEC/WB
//   1100      : HALT         parks in HALT until rst
//   1101-1111 : undefined    sets sticky 'illegal', executes as a NOP
//
// Parameters
//   PC_WIDTH  program counter width in bits (minimum 4)
//   RESET_PC  pc value loaded on reset
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   rst          synchronous active-high reset
//   run          level enable permitting instruction issue
//   instr_req    instruction-memory read request (high in FETCH)
//   pc           fetch address
//   instr_data   fetched instruction
//   instr_valid  instr_data is valid for the current request
//   alu_code     registered ALU code, fed to the ALU op decoder
//   operand      registered immediate operand
//   alu_en       one-cycle execute strobe (high in EXEC)
//   wb_en        one-cycle writeback strobe (high in WB)
//   halted       high while in HALT
//   illegal      sticky flag, set by an undefined ALU code
// -----------------------------------------------------------------------------
module instr_sequencer #(
  parameter int PC_WIDTH = 8,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  output logic                instr_req,
  output logic [PC_WIDTH-1:0] pc,
  input  logic [7:0]          instr_data,
  input  logic                instr_valid,
  output logic [3:0]          alu_code,
  output logic [3:0]          operand,
  output logic                alu_en,
  output logic                wb_en,
  output logic                halted,
  output logic                illegal
);

  localparam logic [3:0] LAST_ALU_CODE = 4'd10;
  localparam logic [3:0] CODE_JUMP     = 4'd11;
  localparam logic [3:0] CODE_HALT     = 4'd12;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] ir;

  // Datapath controls produced by the next-state logic.
  logic capture;      // FETCH handshake: latch instruction, advance pc
  logic decode_exit;  // DECODE exit edge: publish alu_code / operand
  logic do_jump;      // JUMP: pc <= operand
  logic set_illegal;  // undefined code seen

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath-control decode
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default before the case, so
  // no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    capture     = 1'b0;
    decode_exit = 1'b0;
    do_jump     = 1'b0;
    set_illegal = 1'b0;

    case (state)
      IDLE: begin
        if (run) next_state = FETCH;
      end

      FETCH: begin
        if (instr_valid) begin
          capture    = 1'b1;
          next_state = DECODE;
        end
      end

      DECODE: begin
        decode_exit = 1'b1;
        if (ir[7:4] <= LAST_ALU_CODE) begin
          next_state = EXEC;
        end else if (ir[7:4] == CODE_JUMP) begin
          do_jump    = 1'b1;
          next_state = run ? FETCH : IDLE;
        end else if (ir[7:4] == CODE_HALT) begin
          next_state = HALT;
        end else begin
          // Undefined code: flag it and retire as a NOP.
          set_illegal = 1'b1;
          next_state  = run ? FETCH : IDLE;
        end
      end

      EXEC:    next_state = WB;
      WB:      next_state = run ? FETCH : IDLE;
      HALT:    next_state = HALT;
      default: next_state = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: pc, instruction register, decoded fields, sticky illegal flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= PC_WIDTH'(RESET_PC);
      ir       <= '0;
      alu_code <= '0;
      operand  <= '0;
      illegal  <= 1'b0;
    end else begin
      if (capture) begin
        ir <= instr_data;
        pc <= pc + PC_WIDTH'(1);  // wraps silently at 2^PC_WIDTH
      end
      if (decode_exit) begin
        alu_code <= ir[7:4];
        operand  <= ir[3:0];
      end
      // capture and do_jump come from different states, never together.
      if (do_jump)     pc      <= PC_WIDTH'(ir[3:0]);
      if (set_illegal) illegal <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Strobes decoded from the current state only
  // ---------------------------------------------------------------------------
  assign instr_req = (state == FETCH);
  assign alu_en    = (state == EXEC);
  assign wb_en     = (state == WB);
  assign halted    = (state == HALT);

endmodule
